change_dispenser: RTL

- Return-side counterpart to the coin-accepting vending logic.
- Takes a change amount in cents and decomposes it greedily into $5, $1, 25c, 10c and 5c coins, skipping any denomination whose tube is empty.
- Issues one coin at a time to the coin-eject mechanism over a valid/ack handshake.
- Keeps per-denomination tallies for the change display and flags any amount it could not pay out.

---
 rtl/change_dispenser.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time.
// The amount is split greedily into $5, $1, 25c, 10c and 5c coins, skipping
// denominations whose tube is empty. Each coin goes to the eject mechanism
// over a valid/ack handshake. Per-denomination tallies, the unpaid remainder
// and a short flag hold for the change display until the next request.
module change_dispenser #(
  parameter int AMT_W   = 10,
  parameter int TALLY_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [AMT_W-1:0]   req_amount,
  output logic               req_ready,
  input  logic               abort,
  input  logic [4:0]         stock_empty,
  output logic               coin_valid,
  output logic [2:0]         coin_sel,
  input  logic               coin_ack,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   remaining,
  output logic [TALLY_W-1:0] tally_five,
  output logic [TALLY_W-1:0] tally_dollar,
  output logic [TALLY_W-1:0] tally_quarter,
  output logic [TALLY_W-1:0] tally_dime,
  output logic [TALLY_W-1:0] tally_nickel
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  // Denomination codes; the code doubles as the stock_empty bit index.
  localparam logic [2:0] SEL_NICKEL  = 3'd0;
  localparam logic [2:0] SEL_DIME    = 3'd1;
  localparam logic [2:0] SEL_QUARTER = 3'd2;
  localparam logic [2:0] SEL_DOLLAR  = 3'd3;
  localparam logic [2:0] SEL_FIVE    = 3'd4;

  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

  state_t state;
  state_t state_next;

  // Tally per denomination, indexed by coin code.
  logic [TALLY_W-1:0] tally [5];

  logic               pick_found;
  logic [2:0]         pick_sel;
  logic [AMT_W-1:0]   rem_after_ack;

  // Cent value of a denomination code.
  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] sel);
    case (sel)
      SEL_FIVE:    coin_value = AMT_W'(500);
      SEL_DOLLAR:  coin_value = AMT_W'(100);
      SEL_QUARTER: coin_value = AMT_W'(25);
      SEL_DIME:    coin_value = AMT_W'(10);
      SEL_NICKEL:  coin_value = AMT_W'(5);
      default:     coin_value = '0;
    endcase
  endfunction

  // Greedy pick: largest stocked coin not exceeding what is still owed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    pick_found = 1'b0;
    pick_sel   = SEL_NICKEL;
    for (int i = 4; i >= 0; i--) begin
      if (!pick_found && !stock_empty[i] && (remaining >= coin_value(3'(i)))) begin
        pick_found = 1'b1;
        pick_sel   = 3'(i);
      end
    end
  end

  // Amount left once the coin currently on offer is acknowledged.
  assign rem_after_ack = remaining - coin_value(coin_sel);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; abort only matters while a payout is in progress.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) state_next = S_SELECT;
      end
      S_SELECT: begin
        if (abort)           state_next = S_DONE;
        else if (pick_found) state_next = S_WAIT_ACK;
        else                 state_next = S_DONE;
      end
      S_WAIT_ACK: begin
        if (coin_ack)   state_next = abort ? S_DONE : S_SELECT;
        else if (abort) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Payout datapath: remainder, selected coin, short flag and tallies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      coin_sel  <= SEL_NICKEL;
      short     <= 1'b0;
      for (int i = 0; i < 5; i++) tally[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            remaining <= req_amount;
            short     <= 1'b0;
            for (int i = 0; i < 5; i++) tally[i] <= '0;
          end
        end
        S_SELECT: begin
          if (abort)           short    <= (remaining != '0);
          else if (pick_found) coin_sel <= pick_sel;
          else                 short    <= (remaining != '0);
        end
        S_WAIT_ACK: begin
          if (coin_ack) begin
            remaining <= rem_after_ack;
            for (int i = 0; i < 5; i++) begin
              if ((coin_sel == 3'(i)) && (tally[i] != TALLY_MAX))
                tally[i] <= tally[i] + TALLY_W'(1);
            end
            if (abort) short <= (rem_after_ack != '0);
          end else if (abort) begin
            short <= (remaining != '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status decode straight from state, so reset drops coin_valid at once.
  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign coin_valid = (state == S_WAIT_ACK);
  assign done       = (state == S_DONE);

  assign tally_nickel  = tally[SEL_NICKEL];
  assign tally_dime    = tally[SEL_DIME];
  assign tally_quarter = tally[SEL_QUARTER];
  assign tally_dollar  = tally[SEL_DOLLAR];
  assign tally_five    = tally[SEL_FIVE];

endmodule
